// File: rtl/uff_pkg.sv
// Shared constants for the universal flip-flop bank: per-bank mode encoding
// and the illegal-SR predicate used by each cell.
package uff_pkg;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  function automatic logic sr_illegal(input logic [1:0] mode, input logic s, input logic r);
    return (mode == MODE_SR) && s && r;
  endfunction

endpackage

// File: rtl/uff_cell.sv
// One bit of the universal flip-flop bank: D/T/JK/SR next-state, a change
// pulse and a sticky illegal-SR flag.
module uff_cell
  import uff_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       err_clr,
  input  logic       rst_val,
  output logic       q,
  output logic       chg,
  output logic       err
);

  logic nxt;
  logic ill;

  always_comb begin
    nxt = q;
    unique case (mode)
      MODE_D:  nxt = a;
      MODE_T:  nxt = q ^ a;
      MODE_JK: nxt = (a & ~q) | (~b & q);
      MODE_SR: begin
        if (a && !b)      nxt = 1'b1;
        else if (!a && b) nxt = 1'b0;
        else              nxt = q;
      end
    endcase
  end

  assign ill = en & sr_illegal(mode, a, b);

  // Set beats clear so an illegal SR seen together with err_clr is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= rst_val;
      chg <= 1'b0;
      err <= 1'b0;
    end else begin
      if (en) q <= nxt;
      chg <= en & (nxt ^ q);
      err <= ill | (err & ~err_clr);
    end
  end

endmodule

// File: rtl/universal_ff_bank.sv
// Bank of WIDTH independent flip-flops sharing one mode select; adds the
// complemented output and the error OR-reduction on top of the cells.
module universal_ff_bank
  import uff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] err,
  output logic             err_any
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    uff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .err_clr (err_clr),
      .rst_val (RST_VAL[i]),
      .q       (q[i]),
      .chg     (chg[i]),
      .err     (err[i])
    );
  end

  assign qb      = ~q;
  assign err_any = |err;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Self-checking bench for universal_ff_bank (WIDTH=4): directed sequence with
// literal expectations, then randomized traffic against a vector-level model.
module tb_universal_ff_bank;
  import uff_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = MODE_D;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] q, qb, chg, err;
  logic         err_any;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  logic [W-1:0] mq, mchg, merr;

  universal_ff_bank #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .err_clr(err_clr), .q(q), .qb(qb), .chg(chg), .err(err), .err_any(err_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-vector equations straight from the flip-flop truth tables.
  always @(posedge clk or posedge rst) begin
    logic [W-1:0] nq;
    if (rst) begin
      mq = '0; mchg = '0; merr = '0;
    end else begin
      case (mode)
        MODE_D:  nq = a;
        MODE_T:  nq = mq ^ a;
        MODE_JK: nq = (a & ~mq) | (~b & mq);
        default: nq = (mq | (a & ~b)) & ~(~a & b);
      endcase
      if (!en) nq = mq;
      mchg = nq ^ mq;
      merr = (err_clr ? '0 : merr) | ((en && mode == MODE_SR) ? (a & b) : '0);
      mq   = nq;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("q",       q,   mq);
      check("qb",      qb,  ~mq);
      check("chg",     chg, mchg);
      check("err",     err, merr);
      check("err_any", {3'b000, err_any}, {3'b000, |merr});
    end
  end

  task automatic step(input logic e, input logic [1:0] m, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic clr);
    en = e; mode = m; a = av; b = bv; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    check("rst_q", q, 4'b0000);
    check("rst_qb", qb, 4'b1111);

    step(1, MODE_D, 4'b1010, 4'b0000, 0);
    check("d_q", q, 4'b1010);
    check("d_chg", chg, 4'b1010);
    step(1, MODE_T, 4'b0110, 4'b0000, 0);
    check("t_q", q, 4'b1100);
    check("t_chg", chg, 4'b0110);
    step(1, MODE_JK, 4'b1010, 4'b0110, 0);
    check("jk_q", q, 4'b1010);
    step(1, MODE_SR, 4'b0011, 4'b0101, 0);
    check("sr_q", q, 4'b1010);
    check("sr_err", err, 4'b0001);
    check("sr_err_any", {3'b000, err_any}, 4'b0001);
    step(1, MODE_SR, 4'b0011, 4'b0101, 1);
    check("sr_setwins", err, 4'b0001);
    step(1, MODE_SR, 4'b0000, 4'b0000, 1);
    check("sr_clr", err, 4'b0000);

    for (int k = 0; k < 3; k++) begin
      step(0, MODE_T, 4'b1111, 4'b1111, 0);
      check("en0_q", q, 4'b1010);
      check("en0_chg", chg, 4'b0000);
    end
    step(0, MODE_SR, 4'b1111, 4'b1111, 0);
    check("en0_err", err, 4'b0000);

    // Async reset mid-cycle with an illegal SR pending across the next edge.
    en = 1; mode = MODE_SR; a = 4'b1111; b = 4'b1111; err_clr = 0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_q", q, 4'b0000);
    check("arst_qb", qb, 4'b1111);
    check("arst_chg", chg, 4'b0000);
    check("arst_err", err, 4'b0000);
    @(posedge clk);
    #2;
    en = 0;
    rst = 1'b0;
    step(0, MODE_D, 4'b0000, 4'b0000, 0);
    check("rel_q", q, 4'b0000);
    check("rel_err", err, 4'b0000);
    check("rel_chg", chg, 4'b0000);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
           4'($urandom), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 40) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
      end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
